// File: rtl/jtpopeye_psg_bus_if.sv
// CPU-facing AY-3-8910 bus: BDIR/BC1 mode lines, data in and registered read data.
// The CPU side uses the master modport and the PSG responder uses the slave modport.
interface jtpopeye_psg_bus_if;
    logic       bdir;
    logic       bc1;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output bdir, output bc1, output din, input dout);
    modport slave  (input bdir, input bc1, input din, output dout);
endinterface

// File: rtl/jtpopeye_psg_bus.sv
// AY-3-8910 bus responder: mode decode, address latch, 16x8 register file, IO ports.
// Optional macro JTPOPEYE_PSG_RDMASK_EN: reads of R0-R13 return AY-masked values.
module jtpopeye_psg_bus #(
    parameter logic [3:0] CHIP_ADDR = 4'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    jtpopeye_psg_bus_if.slave      bus,
    input  logic [7:0]             IOA_in,
    input  logic [7:0]             IOB_in,
    output logic [7:0]             IOA_out,
    output logic [7:0]             IOB_out,
    output logic [127:0]           regs,
    output logic                   wr_stb,
    output logic [3:0]             wr_addr,
    output logic                   eg_restart
);

    typedef enum logic [1:0] {
        INACTIVE = 2'b00,
        READ     = 2'b01,
        WRITE    = 2'b10,
        LATCH    = 2'b11
    } mode_t;

    function automatic logic [7:0] ay_mask(input logic [3:0] idx);
        case (idx)
            4'd1, 4'd3, 4'd5, 4'd13:  ay_mask = 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10:  ay_mask = 8'h1F;
            default:                  ay_mask = 8'hFF;
        endcase
    endfunction

    mode_t      mode;
    mode_t      mode_prev_reg, mode_prev_next;
    logic [3:0] addr_reg, addr_next;
    logic       sel_reg, sel_next;
    logic [7:0] dout_reg, dout_next;
    logic       wr_stb_reg, wr_stb_next;
    logic [3:0] wr_addr_reg, wr_addr_next;
    logic       eg_restart_reg, eg_restart_next;
    logic [7:0] ioa_out_reg, iob_out_reg;
    logic [7:0] rf_reg  [16];
    logic [7:0] rf_next [16];
    logic [7:0] rd_data;

    assign mode = mode_t'({bus.bdir, bus.bc1});

    // Read mux; ports 14/15 return pin state unless configured as outputs in R7
    always_comb begin
        rd_data = 8'hFF;
        if (sel_reg) begin
            case (addr_reg)
                4'd14:   rd_data = rf_reg[7][6] ? rf_reg[14] : IOA_in;
                4'd15:   rd_data = rf_reg[7][7] ? rf_reg[15] : IOB_in;
`ifdef JTPOPEYE_PSG_RDMASK_EN
                default: rd_data = rf_reg[addr_reg] & ay_mask(addr_reg);
`else
                default: rd_data = rf_reg[addr_reg];
`endif
            endcase
        end
    end

    always_comb begin
        mode_prev_next  = mode_prev_reg;
        addr_next       = addr_reg;
        sel_next        = sel_reg;
        dout_next       = dout_reg;
        wr_stb_next     = 1'b0;
        wr_addr_next    = wr_addr_reg;
        eg_restart_next = 1'b0;
        rf_next         = rf_reg;
        if (clk_en) begin
            mode_prev_next = mode;
            case (mode)
                LATCH: begin
                    addr_next = bus.din[3:0];
                    sel_next  = (bus.din[7:4] == CHIP_ADDR);
                end
                WRITE: begin
                    // Only the first sample of a write transaction commits
                    if (mode_prev_reg != WRITE && sel_reg) begin
                        rf_next[addr_reg] = bus.din;
                        wr_addr_next      = addr_reg;
                        wr_stb_next       = 1'b1;
                        eg_restart_next   = (addr_reg == 4'd13);
                    end
                end
                READ:    dout_next = rd_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_prev_reg  <= INACTIVE;
            addr_reg       <= 4'd0;
            sel_reg        <= 1'b1;
            dout_reg       <= 8'hFF;
            wr_stb_reg     <= 1'b0;
            wr_addr_reg    <= 4'd0;
            eg_restart_reg <= 1'b0;
            ioa_out_reg    <= 8'hFF;
            iob_out_reg    <= 8'hFF;
            for (int i = 0; i < 16; i++) rf_reg[i] <= 8'h00;
        end else begin
            mode_prev_reg  <= mode_prev_next;
            addr_reg       <= addr_next;
            sel_reg        <= sel_next;
            dout_reg       <= dout_next;
            wr_stb_reg     <= wr_stb_next;
            wr_addr_reg    <= wr_addr_next;
            eg_restart_reg <= eg_restart_next;
            ioa_out_reg    <= rf_reg[7][6] ? rf_reg[14] : 8'hFF;
            iob_out_reg    <= rf_reg[7][7] ? rf_reg[15] : 8'hFF;
            rf_reg         <= rf_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_regs
            assign regs[gi*8 +: 8] = rf_reg[gi] & ay_mask(4'(gi));
        end
    endgenerate

    assign bus.dout   = dout_reg;
    assign IOA_out    = ioa_out_reg;
    assign IOB_out    = iob_out_reg;
    assign wr_stb     = wr_stb_reg;
    assign wr_addr    = wr_addr_reg;
    assign eg_restart = eg_restart_reg;

endmodule

// File: tb/tb_jtpopeye_psg_bus.sv
// Randomized scoreboard bench for jtpopeye_psg_bus with a transaction-level AY bus model.
// Writes and reads queue expectations; a monitor compares them as the DUT responds.
module tb_jtpopeye_psg_bus;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clk_en = 1'b0;
    logic [7:0]   IOA_in = 8'h00;
    logic [7:0]   IOB_in = 8'h00;
    logic [7:0]   IOA_out, IOB_out;
    logic [127:0] regs;
    logic         wr_stb, eg_restart;
    logic [3:0]   wr_addr;

    jtpopeye_psg_bus_if bus ();

    jtpopeye_psg_bus #(.CHIP_ADDR(4'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .bus        (bus.slave),
        .IOA_in     (IOA_in),
        .IOB_in     (IOB_in),
        .IOA_out    (IOA_out),
        .IOB_out    (IOB_out),
        .regs       (regs),
        .wr_stb     (wr_stb),
        .wr_addr    (wr_addr),
        .eg_restart (eg_restart)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            clk_en = ($urandom_range(0, 3) != 0);
        end
    end

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] rq[$];
    int         checks = 0;
    int         failures = 0;

    logic [7:0] m_regs [16];
    logic [3:0] m_addr;
    bit         m_sel;
    logic [1:0] m_prev;

    function automatic logic [7:0] width_mask(input logic [3:0] a);
        if (a == 1 || a == 3 || a == 5 || a == 13) return 8'h0F;
        if (a == 6 || a == 8 || a == 9 || a == 10) return 8'h1F;
        return 8'hFF;
    endfunction

    function automatic logic [7:0] exp_read(input logic [7:0] ioa, input logic [7:0] iob);
        if (!m_sel) return 8'hFF;
        if (m_addr == 14) return m_regs[7][6] ? m_regs[14] : ioa;
        if (m_addr == 15) return m_regs[7][7] ? m_regs[15] : iob;
`ifdef JTPOPEYE_PSG_RDMASK_EN
        return m_regs[m_addr] & width_mask(m_addr);
`else
        return m_regs[m_addr];
`endif
    endfunction

    function automatic logic [127:0] exp_regs();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = m_regs[i] & width_mask(4'(i));
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_addr = 4'd0;
        m_sel  = 1'b1;
        m_prev = 2'b00;
    endtask

    // Wait until n cycles with clk_en high have been sampled by the DUT
    task automatic hold(input int n);
        int c = 0;
        while (c < n) begin
            @(posedge clk);
            if (clk_en) c++;
        end
    endtask

    task automatic drive(input logic [1:0] m, input logic [7:0] d);
        @(negedge clk);
        bus.bdir = m[1];
        bus.bc1  = m[0];
        bus.din  = d;
    endtask

    task automatic op_latch(input logic [7:0] d);
        drive(2'b11, d);
        hold(1 + $urandom_range(0, 1));
        m_addr = d[3:0];
        m_sel  = (d[7:4] == 4'h0);
        m_prev = 2'b11;
        $display("LATCH din=%02h addr=%0d sel=%0d", d, m_addr, m_sel);
    endtask

    task automatic op_write(input logic [7:0] d, input int n);
        bit commit;
        commit = (m_prev != 2'b10) && m_sel;
        drive(2'b10, d);
        if (commit) begin
            m_regs[m_addr] = d;
            wq.push_back('{a: m_addr, d: d});
        end
        hold(n);
        m_prev = 2'b10;
        $display("WRITE din=%02h addr=%0d commit=%0d", d, m_addr, commit);
    endtask

    task automatic op_read(input logic [7:0] ioa, input logic [7:0] iob, input int n);
        @(negedge clk);
        IOA_in   = ioa;
        IOB_in   = iob;
        bus.bdir = 1'b0;
        bus.bc1  = 1'b1;
        for (int i = 0; i < n; i++) rq.push_back(exp_read(ioa, iob));
        hold(n);
        m_prev = 2'b01;
        $display("READ addr=%0d expect=%02h", m_addr, exp_read(ioa, iob));
    endtask

    task automatic op_idle_check();
        drive(2'b00, 8'h00);
        hold(1);
        m_prev = 2'b00;
        #1;
        check("ioa_out", 128'(IOA_out), 128'(m_regs[7][6] ? m_regs[14] : 8'hFF));
        check("iob_out", 128'(IOB_out), 128'(m_regs[7][7] ? m_regs[15] : 8'hFF));
        check("regs", regs, exp_regs());
        $display("IDLE ioa_out=%02h iob_out=%02h", IOA_out, IOB_out);
    endtask

    // Monitor: a committed write shows as wr_stb, a READ sample updates dout
    initial begin
        bit rd;
        wr_t e;
        forever begin
            @(posedge clk);
            rd = clk_en && !rst && !bus.bdir && bus.bc1;
            #1;
            if (rst) continue;
            if (rd) begin
                if (rq.size() == 0) check("dout_unexpected", 128'(dout_val()), 128'hx);
                else check("dout", 128'(bus.dout), 128'(rq.pop_front()));
            end
            if (wr_stb) begin
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_stb_unexpected actual=1 required=0 wr_addr=%0d", wr_addr);
                end else begin
                    e = wq.pop_front();
                    check("wr_addr", 128'(wr_addr), 128'(e.a));
                    check("eg_restart", 128'(eg_restart), 128'(e.a == 4'd13));
                    check("reg_after_write", 128'(regs[e.a*8 +: 8]), 128'(e.d & width_mask(e.a)));
                end
            end else if (eg_restart) begin
                check("eg_restart_without_wr_stb", 128'(eg_restart), 128'(0));
            end
        end
    end

    function automatic logic [7:0] dout_val();
        return bus.dout;
    endfunction

    initial begin
        logic [7:0] d;
        bus.bdir = 1'b0;
        bus.bc1  = 1'b0;
        bus.din  = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", 128'(bus.dout), 128'hFF);
        check("rst_ioa_out", 128'(IOA_out), 128'hFF);
        check("rst_iob_out", 128'(IOB_out), 128'hFF);
        check("rst_regs", regs, 128'h0);
        check("rst_strobes", 128'({wr_stb, eg_restart, wr_addr}), 128'h0);
        @(negedge clk);
        rst = 1'b0;
        op_idle_check();

        // Port A as output, read-back ignores pins
        op_latch(8'h07); op_write(8'h40, 1);
        op_latch(8'h0E); op_write(8'h5A, 1);
        op_idle_check();
        op_read(8'h33, 8'h00, 2);
        // Port B as input returns pins
        op_latch(8'h0F); op_read(8'h00, 8'hC3, 1);
        op_idle_check();
        // Held write commits once, narrow register masking
        op_latch(8'h01); op_write(8'hFF, 4);
        op_idle_check();
        op_read(8'h00, 8'h00, 1);
        // Envelope restart
        op_latch(8'h0D); op_write(8'h0E, 1);
        op_idle_check();
        // Foreign chip select then reselect
        op_latch(8'h10); op_write(8'h55, 2); op_read(8'h00, 8'h00, 1);
        op_idle_check();
        op_latch(8'h02); op_write(8'h12, 1);
        op_idle_check();

        // Reset in the middle of a write; release commits on first clk_en
        op_latch(8'h03);
        drive(2'b10, 8'h77);
        rst = 1'b1;
        model_reset();
        #1;
        check("midrst_regs", regs, 128'h0);
        check("midrst_dout", 128'(bus.dout), 128'hFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_regs[0] = 8'h77;
        wq.push_back('{a: 4'd0, d: 8'h77});
        rst = 1'b0;
        hold(2);
        m_prev = 2'b10;
        op_idle_check();

        for (int k = 0; k < 300; k++) begin
            d = 8'($urandom);
            case ($urandom_range(0, 4))
                0: op_latch({($urandom_range(0, 7) == 0) ? d[7:4] : 4'h0, d[3:0]});
                1, 2: op_write(d, $urandom_range(1, 3));
                3: op_read(8'($urandom), 8'($urandom), $urandom_range(1, 2));
                default: op_idle_check();
            endcase
        end
        op_idle_check();
        repeat (4) @(posedge clk);
        check("write_queue_drained", 128'(wq.size()), 128'(0));
        check("read_queue_drained", 128'(rq.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
